// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the execute-stage branch resolver: state encoding,
// default PC width and the taken decision.
package branch_resolver_pkg;

  localparam int unsigned PC_W_DEFAULT = 32;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  typedef enum logic [1:0] {
    StIdle     = ST_IDLE,
    StRedirect = ST_REDIRECT,
    StFlush    = ST_FLUSH
  } br_state_e;

  function automatic logic branch_taken(logic is_jump, logic is_bne, logic is_blt,
                                        logic not_equal, logic less_than);
    return is_jump | (is_bne & not_equal) | (is_blt & less_than);
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Execute-stage control-flow inputs and front-end redirect/flush outputs.
interface branch_resolver_if import branch_resolver_pkg::*; #(
  parameter int unsigned PC_W  = PC_W_DEFAULT,
  parameter int unsigned CNT_W = 16
);
  logic             ex_valid;
  logic             is_bne;
  logic             is_blt;
  logic             is_jump;
  logic             isNotEqual;
  logic             isLessThan;
  logic [PC_W-1:0]  ex_pc;
  logic [PC_W-1:0]  ex_imm;
  logic             stall;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush_fd;
  logic             flush_dx;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] taken_count;

  modport master (
    output ex_valid, is_bne, is_blt, is_jump, isNotEqual, isLessThan, ex_pc, ex_imm, stall,
    input  redirect_valid, redirect_pc, flush_fd, flush_dx, branch_count, taken_count
  );

  modport slave (
    input  ex_valid, is_bne, is_blt, is_jump, isNotEqual, isLessThan, ex_pc, ex_imm, stall,
    output redirect_valid, redirect_pc, flush_fd, flush_dx, branch_count, taken_count
  );
endinterface

// File: rtl/branch_target_adder.sv
// Branch/jump target: absolute immediate for jumps, word-addressed pc + 1 + imm otherwise.
module branch_target_adder import branch_resolver_pkg::*; #(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic            is_jump,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] ex_imm,
  output logic [PC_W-1:0] target
);
  always_comb begin
    target = is_jump ? ex_imm : (ex_pc + PC_W'(1) + ex_imm);
  end
endmodule

// File: rtl/branch_resolver.sv
// Resolves bne/blt/jump in execute, drives a registered redirect plus flush pulses
// to the front end (predict-not-taken) and keeps saturating branch statistics.
module branch_resolver import branch_resolver_pkg::*; #(
  parameter int unsigned PC_W         = PC_W_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input logic              clock,
  input logic              reset_n,
  branch_resolver_if.slave br
);
  // Counter only ever holds FLUSH_CYCLES-1 down to 1.
  localparam int unsigned   FcW       = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FcW-1:0] FlushLoad = FcW'(FLUSH_CYCLES - 1);

  br_state_e        state_q;
  logic [FcW-1:0]   flush_cnt_q;
  logic             redirect_valid_q;
  logic             flush_q;
  logic [PC_W-1:0]  redirect_pc_q;
  logic [CNT_W-1:0] branch_count_q;
  logic [CNT_W-1:0] taken_count_q;

  logic             accept;
  logic             taken;
  logic [PC_W-1:0]  target;

  branch_target_adder #(
    .PC_W (PC_W)
  ) u_target_adder (
    .is_jump (br.is_jump),
    .ex_pc   (br.ex_pc),
    .ex_imm  (br.ex_imm),
    .target  (target)
  );

  always_comb begin
    accept = (state_q == StIdle) && br.ex_valid && !br.stall &&
             (br.is_bne || br.is_blt || br.is_jump);
    taken  = branch_taken(br.is_jump, br.is_bne, br.is_blt, br.isNotEqual, br.isLessThan);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= StIdle;
      flush_cnt_q      <= '0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= '0;
      branch_count_q   <= '0;
      taken_count_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (branch_count_q != '1) branch_count_q <= branch_count_q + CNT_W'(1);
            if (taken) begin
              if (taken_count_q != '1) taken_count_q <= taken_count_q + CNT_W'(1);
              redirect_pc_q    <= target;
              redirect_valid_q <= 1'b1;
              flush_q          <= 1'b1;
              state_q          <= StRedirect;
            end
          end
        end
        StRedirect: begin
          // Stall holds the redirect in place until fetch can take it.
          if (!br.stall) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            if (FLUSH_CYCLES <= 1) begin
              flush_q <= 1'b0;
              state_q <= StIdle;
            end else begin
              flush_cnt_q <= FlushLoad;
              state_q     <= StFlush;
            end
          end
        end
        StFlush: begin
          if (!br.stall) begin
            if (flush_cnt_q <= FcW'(1)) begin
              flush_cnt_q <= '0;
              flush_q     <= 1'b0;
              state_q     <= StIdle;
            end else begin
              flush_cnt_q <= flush_cnt_q - FcW'(1);
            end
          end
        end
        default: begin
          state_q          <= StIdle;
          flush_cnt_q      <= '0;
          redirect_valid_q <= 1'b0;
          flush_q          <= 1'b0;
        end
      endcase
    end
  end

  assign br.redirect_valid = redirect_valid_q;
  assign br.redirect_pc    = redirect_pc_q;
  assign br.flush_fd       = flush_q;
  assign br.flush_dx       = flush_q;
  assign br.branch_count   = branch_count_q;
  assign br.taken_count    = taken_count_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: stimulus queues expected redirects,
// a negedge monitor checks each redirect's target, counters, hold and flush length.
module tb_branch_resolver;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 4;

  typedef struct {
    logic [31:0] pc;
    int          bc;
    int          tc;
    int          vc;
    int          fc;
  } exp_t;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  branch_resolver_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bif ();

  branch_resolver #(
    .PC_W         (PC_W),
    .FLUSH_CYCLES (2),
    .CNT_W        (CNT_W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .br      (bif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input int bc, input int tc, input int vc,
                      input int fc);
    exp_t e;
    e.pc = pc;
    e.bc = bc;
    e.tc = tc;
    e.vc = vc;
    e.fc = fc;
    sb.push_back(e);
  endtask

  // Drive one cycle of execute-stage inputs (stall untouched).
  task automatic step(input logic v, input logic bne, input logic blt, input logic jmp,
                      input logic ne, input logic lt, input logic [31:0] pc,
                      input logic [31:0] imm);
    bif.ex_valid   = v;
    bif.is_bne     = bne;
    bif.is_blt     = blt;
    bif.is_jump    = jmp;
    bif.isNotEqual = ne;
    bif.isLessThan = lt;
    bif.ex_pc      = pc;
    bif.ex_imm     = imm;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_redirect_valid"}, 32'(bif.redirect_valid), 32'h0);
    check({tag, "_redirect_pc"}, bif.redirect_pc, 32'h0);
    check({tag, "_flush_fd"}, 32'(bif.flush_fd), 32'h0);
    check({tag, "_flush_dx"}, 32'(bif.flush_dx), 32'h0);
    check({tag, "_branch_count"}, 32'(bif.branch_count), 32'h0);
    check({tag, "_taken_count"}, 32'(bif.taken_count), 32'h0);
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Monitor
  logic pv, pf, active;
  int   vrun, frun;
  exp_t cur;

  initial begin
    pv = 1'b0;
    pf = 1'b0;
    active = 1'b0;
    vrun = 0;
    frun = 0;
  end

  always @(negedge clock) begin
    if (bif.redirect_valid && !pv) begin
      if (sb.size() == 0) begin
        check("unexpected_redirect", 32'(bif.redirect_valid), 32'h0);
        active = 1'b0;
      end else begin
        cur    = sb.pop_front();
        active = 1'b1;
        vrun   = 0;
        frun   = 0;
        check("redirect_branch_count", 32'(bif.branch_count), 32'(cur.bc));
        check("redirect_taken_count", 32'(bif.taken_count), 32'(cur.tc));
      end
    end
    if (bif.flush_fd && !pf) check("flush_with_redirect", 32'(bif.redirect_valid), 32'h1);
    if (active) begin
      if (bif.redirect_valid) begin
        vrun++;
        check("redirect_pc", bif.redirect_pc, cur.pc);
      end
      if (bif.flush_fd) frun++;
    end
    check("flush_fd_eq_dx", 32'(bif.flush_fd), 32'(bif.flush_dx));
    if (active && !bif.flush_fd && pf) begin
      check("redirect_cycles", 32'(vrun), 32'(cur.vc));
      check("flush_cycles", 32'(frun), 32'(cur.fc));
      active = 1'b0;
    end
    pv = bif.redirect_valid;
    pf = bif.flush_fd;
  end

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    bif.stall = 1'b0;
    bif.ex_valid = 1'b0;
    bif.is_bne = 1'b0;
    bif.is_blt = 1'b0;
    bif.is_jump = 1'b0;
    bif.isNotEqual = 1'b0;
    bif.isLessThan = 1'b0;
    bif.ex_pc = '0;
    bif.ex_imm = '0;
    @(negedge clock);
    @(negedge clock);
    check_zero("reset");
    reset_n = 1'b1;

    // bne taken: 0x10 + 1 + 5
    push(32'h16, 1, 1, 1, 2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h5);
    idle(4);

    // blt not taken, then a jump the very next cycle
    pulse_reset();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h3);
    check("nt_redirect_valid", 32'(bif.redirect_valid), 32'h0);
    check("nt_flush_fd", 32'(bif.flush_fd), 32'h0);
    check("nt_branch_count", 32'(bif.branch_count), 32'h1);
    check("nt_taken_count", 32'(bif.taken_count), 32'h0);
    push(32'h40, 2, 1, 1, 2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h21, 32'h40);
    idle(4);

    // ex_valid low with type bits set: nothing happens
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h30, 32'h30);
    idle(2);
    check("novalid_branch_count", 32'(bif.branch_count), 32'h2);

    // stall held 3 cycles in REDIRECT: 4 valid cycles, 5 flush cycles
    pulse_reset();
    push(32'h121, 1, 1, 4, 5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h20);
    bif.stall = 1'b1;
    idle(3);
    bif.stall = 1'b0;
    idle(4);

    // wrong-path blt (REDIRECT) and jump (FLUSH) are dropped; negative offset
    pulse_reset();
    push(32'h7, 1, 1, 1, 2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h8, 32'hFFFF_FFFE);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h9, 32'h4);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA, 32'h99);
    idle(3);
    check("drop_branch_count", 32'(bif.branch_count), 32'h1);
    check("drop_taken_count", 32'(bif.taken_count), 32'h1);

    // 20 taken jumps saturate both 4-bit counters at 15
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      push(32'h200 + 32'(i), (i + 1 > 15) ? 15 : i + 1, (i + 1 > 15) ? 15 : i + 1, 1, 2);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h200 + 32'(i));
      idle(2);
    end
    check("sat_branch_count", 32'(bif.branch_count), 32'hF);
    check("sat_taken_count", 32'(bif.taken_count), 32'hF);

    // target wraps modulo 2^32
    push(32'h0, 15, 15, 1, 2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    idle(3);

    // reset during the second flush cycle drops everything immediately
    pulse_reset();
    push(32'h300, 1, 1, 1, 2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h300);
    idle(1);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("midflush");
    @(negedge clock);
    reset_n = 1'b1;
    idle(3);
    check("postrst_redirect_valid", 32'(bif.redirect_valid), 32'h0);
    check("postrst_flush_fd", 32'(bif.flush_fd), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h50, 32'h5);
    check("postrst_branch_count", 32'(bif.branch_count), 32'h1);
    check("postrst_taken_count", 32'(bif.taken_count), 32'h0);
    idle(3);

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
